// File: rtl/match_pkg.sv
// Shared constants, FSM encoding and cell indexing for the match/clear scanner.
// Board cell (r,c) lives at flat index r*N+c.
package match_pkg;
  localparam int N          = 8;
  localparam int CELL_W     = 3;
  localparam int SCORE_W    = 16;
  localparam int CELLS      = N * N;
  localparam int BOARD_W    = CELLS * CELL_W;
  localparam int LINE_IDX_W = $clog2(N);
  localparam int CELL_IDX_W = $clog2(CELLS);
  localparam int COUNT_W    = $clog2(CELLS + 1);

  localparam logic [CELL_W-1:0] EMPTY = '0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ROW   = 3'd1,
    S_COL   = 3'd2,
    S_APPLY = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic [CELL_IDX_W-1:0] cell_idx(input logic [LINE_IDX_W-1:0] r,
                                                     input logic [LINE_IDX_W-1:0] c);
    return CELL_IDX_W'(int'(r) * N + int'(c));
  endfunction
endpackage

// File: rtl/match_clear_if.sv
// Board-in / cleared-board-out bundle between the board owner and match_clear.
interface match_clear_if;
  import match_pkg::*;

  logic                 start;
  logic                 score_clr;
  logic [BOARD_W-1:0]   board;
  logic                 busy;
  logic                 done;
  logic [BOARD_W-1:0]   cleared_board;
  logic [CELLS-1:0]     clear_mask;
  logic [COUNT_W-1:0]   clear_count;
  logic                 match_found;
  logic [SCORE_W-1:0]   score;

  modport master (
    output start, score_clr, board,
    input  busy, done, cleared_board, clear_mask, clear_count, match_found, score
  );

  modport slave (
    input  start, score_clr, board,
    output busy, done, cleared_board, clear_mask, clear_count, match_found, score
  );
endinterface

// File: rtl/line_match8.sv
// Combinational run detector for one line of N cells: marks every cell that sits
// in a run of three or more equal non-empty cells.
module line_match8
  import match_pkg::*;
(
  input  logic [N*CELL_W-1:0] cells,
  output logic [N-1:0]        mask
);
  // trip_ext[j+2] flags a matching triple starting at cell j; the padding keeps
  // the per-cell OR below free of range checks at both line ends.
  logic [N+1:0] trip_ext;

  generate
    for (genvar gi = 0; gi < N + 2; gi++) begin : g_trip
      if (gi >= 2 && gi <= N - 1) begin : g_real
        logic [CELL_W-1:0] a, b, c;
        assign a = cells[(gi-2)*CELL_W +: CELL_W];
        assign b = cells[(gi-1)*CELL_W +: CELL_W];
        assign c = cells[gi*CELL_W +: CELL_W];
        assign trip_ext[gi] = (a != EMPTY) && (a == b) && (b == c);
      end else begin : g_pad
        assign trip_ext[gi] = 1'b0;
      end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_mask
      assign mask[gi] = trip_ext[gi] | trip_ext[gi+1] | trip_ext[gi+2];
    end
  endgenerate
endmodule

// File: rtl/match_clear.sv
// Sequential match eliminator: scans the latched board row by row, then column by
// column, through one shared line detector, then zeroes matched cells and scores them.
module match_clear
  import match_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  match_clear_if.slave  bus
);
  state_t                 state_reg, state_next;
  logic [BOARD_W-1:0]     latch_reg;
  logic [CELLS-1:0]       work_mask_reg;
  logic [LINE_IDX_W-1:0]  idx_reg;
  logic [BOARD_W-1:0]     cleared_board_reg, cleared_board_next;
  logic [CELLS-1:0]       clear_mask_reg;
  logic [COUNT_W-1:0]     clear_count_reg, clear_count_next;
  logic                   match_found_reg;
  logic [SCORE_W-1:0]     score_reg, score_next;
  logic [SCORE_W:0]       score_sum;

  logic [CELL_W-1:0]      cell_arr [CELLS];
  logic [N*CELL_W-1:0]    line_cells;
  logic [N-1:0]           line_mask;
  logic [CELLS-1:0]       line_spread;
  logic                   last_idx;

  assign last_idx = (idx_reg == LINE_IDX_W'(N - 1));

  generate
    for (genvar gi = 0; gi < CELLS; gi++) begin : g_cells
      assign cell_arr[gi] = latch_reg[gi*CELL_W +: CELL_W];
      assign cleared_board_next[gi*CELL_W +: CELL_W] =
          work_mask_reg[gi] ? EMPTY : latch_reg[gi*CELL_W +: CELL_W];
      // Scatter the line result back to board positions for the current row or column.
      assign line_spread[gi] =
          ((state_reg == S_ROW) && (idx_reg == LINE_IDX_W'(gi / N)) && line_mask[gi % N]) ||
          ((state_reg == S_COL) && (idx_reg == LINE_IDX_W'(gi % N)) && line_mask[gi / N]);
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_line
      assign line_cells[gi*CELL_W +: CELL_W] = (state_reg == S_ROW)
          ? cell_arr[cell_idx(idx_reg, LINE_IDX_W'(gi))]
          : cell_arr[cell_idx(LINE_IDX_W'(gi), idx_reg)];
    end
  endgenerate

  line_match8 u_line (
    .cells (line_cells),
    .mask  (line_mask)
  );

  assign clear_count_next = COUNT_W'($countones(work_mask_reg));
  assign score_sum        = {1'b0, score_reg} + (SCORE_W+1)'(clear_count_next);
  assign score_next       = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (bus.start) state_next = S_ROW;
      S_ROW:   if (last_idx)  state_next = S_COL;
      S_COL:   if (last_idx)  state_next = S_APPLY;
      S_APPLY: state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state_reg)
      S_ROW, S_COL, S_APPLY: bus.busy = 1'b1;
      S_DONE:                bus.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_reg         <= '0;
      work_mask_reg     <= '0;
      idx_reg           <= '0;
      cleared_board_reg <= '0;
      clear_mask_reg    <= '0;
      clear_count_reg   <= '0;
      match_found_reg   <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            latch_reg     <= bus.board;
            work_mask_reg <= '0;
            idx_reg       <= '0;
          end
        end
        S_ROW, S_COL: begin
          work_mask_reg <= work_mask_reg | line_spread;
          idx_reg       <= last_idx ? '0 : idx_reg + 1'b1;
        end
        S_APPLY: begin
          cleared_board_reg <= cleared_board_next;
          clear_mask_reg    <= work_mask_reg;
          clear_count_reg   <= clear_count_next;
          match_found_reg   <= (clear_count_next != '0);
        end
        default: ;
      endcase
    end
  end

  // A same-cycle clear wins over the APPLY accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_reg <= '0;
    end else if (bus.score_clr) begin
      score_reg <= '0;
    end else if (state_reg == S_APPLY) begin
      score_reg <= score_next;
    end
  end

  assign bus.cleared_board = cleared_board_reg;
  assign bus.clear_mask    = clear_mask_reg;
  assign bus.clear_count   = clear_count_reg;
  assign bus.match_found   = match_found_reg;
  assign bus.score         = score_reg;
endmodule
